// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritised write ports, two combinational read
// ports with optional bypass, optional hardwired zero register and busy scoreboard.
module regfile_mp #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic        [ADDR_W-1:0] ra,
    input  logic        [ADDR_W-1:0] rb,
    output logic signed [DATA_W-1:0] rd_a_data,
    output logic signed [DATA_W-1:0] rd_b_data,
    input  logic                     wr0_en,
    input  logic        [ADDR_W-1:0] wr0_addr,
    input  logic signed [DATA_W-1:0] wr0_data,
    input  logic                     wr1_en,
    input  logic        [ADDR_W-1:0] wr1_addr,
    input  logic signed [DATA_W-1:0] wr1_data,
    input  logic                     rsv_en,
    input  logic        [ADDR_W-1:0] rsv_addr,
    output logic                     rsv_ack,
    output logic                     busy_a,
    output logic                     busy_b,
    input  logic                     flush,
    output logic                     wr_collision
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regFile_q [DEPTH];
    logic [DATA_W-1:0] regFile_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic              wrCollision_q, wrCollision_d;

    logic wr0Commit, wr1Commit, rsvCommit;
    logic wr0ZeroHit, wr1ZeroHit, rsvZeroHit, raZeroHit, rbZeroHit;
    logic sameWrAddr;
    logic hitA, hitB;

    assign wr0ZeroHit = (ZERO_REG != 0) && (wr0_addr == '0);
    assign wr1ZeroHit = (ZERO_REG != 0) && (wr1_addr == '0);
    assign rsvZeroHit = (ZERO_REG != 0) && (rsv_addr == '0);
    assign raZeroHit  = (ZERO_REG != 0) && (ra == '0);
    assign rbZeroHit  = (ZERO_REG != 0) && (rb == '0);

    // Port 1 loses a same-address race; the zero register swallows all writes.
    assign sameWrAddr = wr0_en && wr1_en && (wr0_addr == wr1_addr);
    assign wr0Commit  = wr0_en && !wr0ZeroHit;
    assign wr1Commit  = wr1_en && !sameWrAddr && !wr1ZeroHit;

    assign rsv_ack   = rsv_en && !busy_q[rsv_addr] && !flush;
    assign rsvCommit = rsv_ack && !rsvZeroHit;

    assign hitA   = (wr0_en && (wr0_addr == ra)) || (wr1_en && (wr1_addr == ra));
    assign hitB   = (wr0_en && (wr0_addr == rb)) || (wr1_en && (wr1_addr == rb));
    assign busy_a = busy_q[ra] && !hitA;
    assign busy_b = busy_q[rb] && !hitB;

    assign wr_collision = wrCollision_q;

    always_comb begin
        regFile_d = regFile_q;
        if (wr1Commit) regFile_d[wr1_addr] = wr1_data;
        if (wr0Commit) regFile_d[wr0_addr] = wr0_data;
    end

    // Flush overrides everything; an accepted reserve overrides a same-cycle write clear.
    always_comb begin
        busy_d = busy_q;
        if (wr0_en) busy_d[wr0_addr] = 1'b0;
        if (wr1_en) busy_d[wr1_addr] = 1'b0;
        if (rsvCommit) busy_d[rsv_addr] = 1'b1;
        if (flush) busy_d = '0;
    end

    assign wrCollision_d = sameWrAddr;

    always_comb begin
        rd_a_data = regFile_q[ra];
        if (raZeroHit) begin
            rd_a_data = '0;
        end else if ((BYPASS != 0) && wr0_en && (wr0_addr == ra)) begin
            rd_a_data = wr0_data;
        end else if ((BYPASS != 0) && wr1_en && (wr1_addr == ra)) begin
            rd_a_data = wr1_data;
        end
    end

    always_comb begin
        rd_b_data = regFile_q[rb];
        if (rbZeroHit) begin
            rd_b_data = '0;
        end else if ((BYPASS != 0) && wr0_en && (wr0_addr == rb)) begin
            rd_b_data = wr0_data;
        end else if ((BYPASS != 0) && wr1_en && (wr1_addr == rb)) begin
            rd_b_data = wr1_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regFile_q     <= '{default: '0};
            busy_q        <= '0;
            wrCollision_q <= 1'b0;
        end else begin
            regFile_q     <= regFile_d;
            busy_q        <= busy_d;
            wrCollision_q <= wrCollision_d;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default, no-bypass and zero-register instances
// share one stimulus stream and are checked against hand-computed values.
module tb_regfile_mp;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] ra, rb, wr0Addr, wr1Addr, rsvAddr;
    logic [7:0] wr0Data, wr1Data;
    logic       wr0En, wr1En, rsvEn, flush;

    logic [7:0] rdA0, rdB0, rdANb, rdBNb, rdAZr, rdBZr;
    logic       ack0, ackNb, ackZr;
    logic       busyA0, busyB0, busyANb, busyBNb, busyAZr, busyBZr;
    logic       coll0, collNb, collZr;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0), .BYPASS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rb(rb),
        .rd_a_data(rdA0), .rd_b_data(rdB0),
        .wr0_en(wr0En), .wr0_addr(wr0Addr), .wr0_data(wr0Data),
        .wr1_en(wr1En), .wr1_addr(wr1Addr), .wr1_data(wr1Data),
        .rsv_en(rsvEn), .rsv_addr(rsvAddr), .rsv_ack(ack0),
        .busy_a(busyA0), .busy_b(busyB0), .flush(flush), .wr_collision(coll0)
    );

    regfile_mp #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0), .BYPASS(0)) uNb (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rb(rb),
        .rd_a_data(rdANb), .rd_b_data(rdBNb),
        .wr0_en(wr0En), .wr0_addr(wr0Addr), .wr0_data(wr0Data),
        .wr1_en(wr1En), .wr1_addr(wr1Addr), .wr1_data(wr1Data),
        .rsv_en(rsvEn), .rsv_addr(rsvAddr), .rsv_ack(ackNb),
        .busy_a(busyANb), .busy_b(busyBNb), .flush(flush), .wr_collision(collNb)
    );

    regfile_mp #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1), .BYPASS(1)) uZr (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rb(rb),
        .rd_a_data(rdAZr), .rd_b_data(rdBZr),
        .wr0_en(wr0En), .wr0_addr(wr0Addr), .wr0_data(wr0Data),
        .wr1_en(wr1En), .wr1_addr(wr1Addr), .wr1_data(wr1Data),
        .rsv_en(rsvEn), .rsv_addr(rsvAddr), .rsv_ack(ackZr),
        .busy_a(busyAZr), .busy_b(busyBZr), .flush(flush), .wr_collision(collZr)
    );

    task automatic applyStimulus(input logic w0e, input logic [1:0] w0a, input logic [7:0] w0d,
                                 input logic w1e, input logic [1:0] w1a, input logic [7:0] w1d,
                                 input logic re, input logic [1:0] rAddr, input logic fl,
                                 input logic [1:0] addrA, input logic [1:0] addrB);
        wr0En = w0e; wr0Addr = w0a; wr0Data = w0d;
        wr1En = w1e; wr1Addr = w1a; wr1Data = w1d;
        rsvEn = re;  rsvAddr = rAddr; flush = fl;
        ra = addrA;  rb = addrB;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0);
        tick();
        tick();
        checkOutput("reset rd_a", rdA0, 8'h00);
        checkOutput("reset busy_a", {7'b0, busyA0}, 8'h00);
        checkOutput("reset collision", {7'b0, coll0}, 8'h00);
        rst_n = 1'b1;

        // Load some state, then reset asynchronously mid-cycle
        applyStimulus(1, 1, 8'hAA, 0, 0, 8'h00, 1, 3, 0, 1, 3);
        checkOutput("rsv reg3 ack", {7'b0, ack0}, 8'h01);
        tick();
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 3);
        checkOutput("pre-reset rd_a reg1", rdA0, 8'hAA);
        checkOutput("pre-reset busy_b reg3", {7'b0, busyB0}, 8'h01);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset rd_a", rdA0, 8'h00);
        checkOutput("async reset busy_b", {7'b0, busyB0}, 8'h00);
        applyStimulus(1, 2, 8'h55, 0, 0, 8'h00, 1, 1, 0, 2, 1);
        tick();
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 2, 1);
        checkOutput("write during reset ignored", rdA0, 8'h00);
        checkOutput("reserve during reset ignored", {7'b0, busyB0}, 8'h00);
        rst_n = 1'b1;

        // Readback and bypass
        applyStimulus(1, 2, 8'h85, 0, 0, 8'h00, 0, 0, 0, 2, 2);
        checkOutput("bypass wr0 reg2", rdA0, 8'h85);
        checkOutput("no-bypass old reg2", rdANb, 8'h00);
        tick();
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 2, 2);
        checkOutput("readback reg2", rdA0, 8'h85);
        checkOutput("no-bypass readback reg2", rdANb, 8'h85);
        tick();
        applyStimulus(1, 1, 8'h3C, 0, 0, 8'h00, 0, 0, 0, 1, 1);
        checkOutput("bypass rd_a reg1", rdA0, 8'h3C);
        checkOutput("bypass rd_b reg1", rdB0, 8'h3C);
        checkOutput("no-bypass rd_a reg1 old", rdANb, 8'h00);
        tick();
        applyStimulus(0, 0, 8'h00, 1, 0, 8'h44, 0, 0, 0, 1, 0);
        checkOutput("no-bypass reg1 after edge", rdANb, 8'h3C);
        checkOutput("bypass wr1 reg0", rdB0, 8'h44);
        checkOutput("zero reg bypass blocked", rdBZr, 8'h00);
        tick();

        // Collision: port 0 wins, one-cycle pulse
        applyStimulus(1, 3, 8'h11, 1, 3, 8'h22, 0, 0, 0, 3, 0);
        checkOutput("collision bypass priority", rdA0, 8'h11);
        checkOutput("no pulse before edge", {7'b0, coll0}, 8'h00);
        tick();
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 3, 0);
        checkOutput("collision reg3 stored", rdANb, 8'h11);
        checkOutput("collision pulse", {7'b0, coll0}, 8'h01);
        checkOutput("reg0 from wr1", rdB0, 8'h44);
        checkOutput("zero reg read", rdBZr, 8'h00);
        tick();
        applyStimulus(1, 0, 8'h01, 1, 2, 8'h02, 0, 0, 0, 0, 2);
        checkOutput("pulse one cycle only", {7'b0, coll0}, 8'h00);
        tick();
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 2);
        checkOutput("dual write reg0", rdANb, 8'h01);
        checkOutput("dual write reg2", rdBNb, 8'h02);
        checkOutput("dual write no pulse", {7'b0, coll0}, 8'h00);
        tick();

        // Scoreboard
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 1, 2, 0, 2, 2);
        checkOutput("rsv reg2 ack", {7'b0, ack0}, 8'h01);
        tick();
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 1, 2, 0, 2, 2);
        checkOutput("reg2 busy", {7'b0, busyA0}, 8'h01);
        checkOutput("rsv busy reg2 nack", {7'b0, ack0}, 8'h00);
        tick();
        applyStimulus(0, 0, 8'h00, 1, 2, 8'h7F, 0, 0, 0, 2, 2);
        checkOutput("busy masked by write", {7'b0, busyA0}, 8'h00);
        checkOutput("wr1 bypass reg2", rdA0, 8'h7F);
        tick();
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 2, 2);
        checkOutput("busy cleared reg2", {7'b0, busyA0}, 8'h00);
        checkOutput("reg2 stored 7F", rdANb, 8'h7F);
        tick();

        // Flush priority
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 0, 1, 1);
        tick();
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 1, 3, 0, 1, 3);
        checkOutput("reg1 busy", {7'b0, busyA0}, 8'h01);
        checkOutput("rsv reg3 ack", {7'b0, ack0}, 8'h01);
        tick();
        applyStimulus(1, 1, 8'h05, 0, 0, 8'h00, 1, 0, 1, 3, 1);
        checkOutput("flush blocks ack", {7'b0, ack0}, 8'h00);
        checkOutput("reg3 busy before flush edge", {7'b0, busyA0}, 8'h01);
        tick();
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 3, 0);
        checkOutput("flush cleared reg3", {7'b0, busyA0}, 8'h00);
        checkOutput("flush reg0 not reserved", {7'b0, busyB0}, 8'h00);
        tick();
        applyStimulus(1, 2, 8'h66, 0, 0, 8'h00, 1, 2, 0, 1, 1);
        checkOutput("flush kept write reg1", rdANb, 8'h05);
        checkOutput("reg1 busy after flush", {7'b0, busyA0}, 8'h00);
        checkOutput("rsv with write ack", {7'b0, ack0}, 8'h01);
        tick();
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 2, 2);
        checkOutput("reserve wins over write clear", {7'b0, busyA0}, 8'h01);
        checkOutput("write data with reserve", rdANb, 8'h66);
        tick();

        // Zero register
        applyStimulus(1, 0, 8'hFF, 0, 0, 8'h00, 0, 0, 0, 0, 0);
        checkOutput("zero reg bypass wr0", rdAZr, 8'h00);
        checkOutput("normal reg0 bypass", rdA0, 8'hFF);
        tick();
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 0);
        checkOutput("zero reg after write", rdAZr, 8'h00);
        checkOutput("normal reg0 stored", rdA0, 8'hFF);
        checkOutput("zero reg rsv ack", {7'b0, ackZr}, 8'h01);
        tick();
        applyStimulus(1, 0, 8'h12, 1, 0, 8'h34, 0, 0, 0, 0, 0);
        checkOutput("zero reg never busy", {7'b0, busyAZr}, 8'h00);
        checkOutput("normal reg0 busy masked", {7'b0, busyA0}, 8'h00);
        tick();
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0);
        checkOutput("zero reg collision pulse", {7'b0, collZr}, 8'h01);
        checkOutput("zero reg still zero", rdAZr, 8'h00);
        checkOutput("normal reg0 wr0 wins", rdA0, 8'h12);
        checkOutput("normal reg0 busy cleared", {7'b0, busyA0}, 8'h00);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
